// File: rtl/spi_mem_responder.sv
// SPI/QSPI PSRAM-style responder: oversamples sclk/ce_n/sio on clk, decodes 0x03/0x02/0xEB/0x38
// and turns each serial byte into a one-cycle read or write strobe on a synchronous byte port.
module spi_mem_responder #(
    parameter int ADDR_BITS  = 24,
    parameter int QUAD_DUMMY = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sclk,
    input  logic                 ce_n,
    input  logic [3:0]           sio_i,
    output logic [3:0]           sio_o,
    output logic [3:0]           sio_oe,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_re,
    input  logic [7:0]           mem_rdata,
    output logic                 mem_we,
    output logic [7:0]           mem_wdata
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;
    typedef struct packed {
        logic quad;
        logic rd;
    } mode_t;

    logic [1:0]      sclk_q, ce_q;
    logic [1:0][3:0] sio_q;
    logic            sclk_d, ce_d;

    // ce_n syncs to 1 under reset so leaving reset with the chip deselected is not seen as a select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            ce_q   <= '1;
            sio_q  <= '0;
            sclk_d <= 1'b0;
            ce_d   <= 1'b1;
        end else begin
            sclk_q <= {sclk_q[0], sclk};
            ce_q   <= {ce_q[0], ce_n};
            sio_q  <= {sio_q[0], sio_i};
            sclk_d <= sclk_q[1];
            ce_d   <= ce_q[1];
        end
    end

    logic       sck_rise, sck_fall, ce_fall, ce_hi;
    logic [3:0] sio_s;

    assign sck_rise = sclk_q[1] & ~sclk_d;
    assign sck_fall = ~sclk_q[1] & sclk_d;
    assign ce_fall  = ~ce_q[1] & ce_d;
    assign ce_hi    = ce_q[1];
    assign sio_s    = sio_q[1];

    state_t      state;
    mode_t       mode;
    logic [6:0]  cmd_sr;
    logic [23:0] addr_sr;
    logic [7:0]  cnt;
    logic [2:0]  bcnt;
    logic [7:0]  rbuf, sh, wsh;
    logic        re_d;

    logic [7:0]  cmd_next, wsh_next, dsrc, addr_last;
    logic [23:0] addr_next;
    logic [2:0]  byte_last;

    always_comb begin
        cmd_next  = {cmd_sr, sio_s[0]};
        addr_next = mode.quad ? {addr_sr[19:0], sio_s} : {addr_sr[22:0], sio_s[0]};
        wsh_next  = mode.quad ? {wsh[3:0], sio_s} : {wsh[6:0], sio_s[0]};
        addr_last = mode.quad ? 8'd5 : 8'd23;
        byte_last = mode.quad ? 3'd1 : 3'd7;
        // first bit/nibble of a byte comes from the prefetch buffer, the rest from the shifter
        dsrc      = (bcnt == 3'd0) ? rbuf : sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode      <= '0;
            cmd_sr    <= '0;
            addr_sr   <= '0;
            cnt       <= '0;
            bcnt      <= '0;
            rbuf      <= '0;
            sh        <= '0;
            wsh       <= '0;
            re_d      <= 1'b0;
            sio_o     <= '0;
            sio_oe    <= '0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            re_d   <= mem_re;
            if (re_d)
                rbuf <= mem_rdata;
            // writes strobe at the current address, then step to the next byte
            if (mem_we)
                mem_addr <= mem_addr + ADDR_BITS'(1);

            if (ce_hi && state != IDLE) begin
                state  <= IDLE;
                sio_oe <= '0;
                sio_o  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ce_fall) begin
                            state <= CMD;
                            cnt   <= '0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            cmd_sr <= cmd_next[6:0];
                            cnt    <= cnt + 8'd1;
                            if (cnt == 8'd7) begin
                                cnt   <= '0;
                                state <= ADDR;
                                case (cmd_next)
                                    8'h03:   mode <= '{quad: 1'b0, rd: 1'b1};
                                    8'h02:   mode <= '{quad: 1'b0, rd: 1'b0};
                                    8'hEB:   mode <= '{quad: 1'b1, rd: 1'b1};
                                    8'h38:   mode <= '{quad: 1'b1, rd: 1'b0};
                                    default: state <= IGNORE;
                                endcase
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_rise) begin
                            addr_sr <= addr_next;
                            cnt     <= cnt + 8'd1;
                            if (cnt == addr_last) begin
                                cnt      <= '0;
                                bcnt     <= '0;
                                mem_addr <= ADDR_BITS'(addr_next);
                                if (mode.rd) begin
                                    mem_re <= 1'b1;
                                    if (mode.quad && QUAD_DUMMY > 0) begin
                                        state <= DUMMY;
                                    end else begin
                                        state  <= RDATA;
                                        sio_oe <= mode.quad ? 4'b0000 : 4'b0010;
                                    end
                                end else begin
                                    state <= WDATA;
                                end
                            end
                        end
                    end
                    DUMMY: begin
                        if (sck_rise) begin
                            cnt <= cnt + 8'd1;
                            if (cnt == 8'(QUAD_DUMMY - 1))
                                state <= RDATA;
                        end
                    end
                    RDATA: begin
                        if (sck_fall) begin
                            // starting a byte: fetch the following one while this one shifts out
                            if (bcnt == 3'd0) begin
                                mem_addr <= mem_addr + ADDR_BITS'(1);
                                mem_re   <= 1'b1;
                            end
                            if (mode.quad) begin
                                sio_o  <= dsrc[7:4];
                                sh     <= {dsrc[3:0], 4'h0};
                                sio_oe <= 4'b1111;
                            end else begin
                                sio_o <= {2'b00, dsrc[7], 1'b0};
                                sh    <= {dsrc[6:0], 1'b0};
                            end
                            bcnt <= (bcnt == byte_last) ? 3'd0 : bcnt + 3'd1;
                        end
                    end
                    WDATA: begin
                        if (sck_rise) begin
                            wsh <= wsh_next;
                            if (bcnt == byte_last) begin
                                bcnt      <= '0;
                                mem_wdata <= wsh_next;
                                mem_we    <= 1'b1;
                            end else begin
                                bcnt <= bcnt + 3'd1;
                            end
                        end
                    end
                    IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: an SPI/QSPI master drives directed and random transactions and
// checks read data, write strobes and output enables against a byte-array memory model.
module tb_spi_mem_responder;
    localparam int AB   = 24;
    localparam int QD   = 6;
    localparam int HALF = 50;

    logic          clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, ce_n = 1'b1;
    logic [3:0]    sio_i = 4'h0;
    logic [3:0]    sio_o, sio_oe;
    logic [AB-1:0] mem_addr;
    logic          mem_re, mem_we;
    logic [7:0]    mem_rdata = 8'h00;
    logic [7:0]    mem_wdata;

    always #5 clk = ~clk;

    spi_mem_responder #(.ADDR_BITS(AB), .QUAD_DUMMY(QD)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ce_n(ce_n), .sio_i(sio_i),
        .sio_o(sio_o), .sio_oe(sio_oe), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata)
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory seen by the DUT, and the bench's own expectation of memory contents
    logic [7:0] env_mem [logic [23:0]];
    logic [7:0] ref_mem [logic [23:0]];

    function automatic logic [7:0] init_val(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    always @(posedge clk)
        if (mem_re)
            mem_rdata <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_val(mem_addr);

    logic [31:0] got_w [$];
    int          re_cnt = 0, both_cnt = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            env_mem[mem_addr] = mem_wdata;
            got_w.push_back({mem_addr, mem_wdata});
        end
        if (mem_re) re_cnt++;
        if (mem_re && mem_we) both_cnt++;
    end

    logic [3:0] smp_o, smp_oe;
    logic [7:0] wbuf [8];
    logic [7:0] op_tab [5] = '{8'h03, 8'h02, 8'hEB, 8'h38, 8'h9F};

    // one sclk period, mode 0: data set while sclk low, slave output sampled just before the rise
    task automatic sck(input logic [3:0] d);
        sio_i = d;
        #(HALF);
        smp_o  = sio_o;
        smp_oe = sio_oe;
        sclk = 1'b1;
        #(HALF);
        sclk = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] op, input logic [23:0] a, input int n, input int extra);
        bit          quad, rd, known;
        logic [3:0]  oe_exp;
        logic [7:0]  b;
        logic [23:0] aj;
        int          oe_bad, exp_w, nb;
        quad   = (op == 8'hEB) || (op == 8'h38);
        rd     = (op == 8'h03) || (op == 8'hEB);
        known  = quad || rd || (op == 8'h02);
        oe_exp = (op == 8'hEB) ? 4'hF : 4'h2;
        oe_bad = 0;
        nb     = quad ? 2 : 8;
        got_w.delete();
        re_cnt = 0;
        ce_n = 1'b0;
        #(HALF);
        for (int i = 7; i >= 0; i--) begin
            sck({3'b000, op[i]});
            if (smp_oe !== 4'h0) oe_bad++;
        end
        for (int i = (quad ? 5 : 23); i >= 0; i--) begin
            sck(quad ? a[i*4 +: 4] : {3'b000, a[i]});
            if (smp_oe !== 4'h0) oe_bad++;
        end
        if (op == 8'hEB)
            for (int i = 0; i < QD; i++) begin
                sck(4'h0);
                if (smp_oe !== 4'h0) oe_bad++;
            end
        for (int j = 0; j < n; j++) begin
            aj = a + 24'(j);
            if (rd) begin
                b = 8'h00;
                for (int k = 0; k < nb; k++) begin
                    sck(4'h0);
                    b = quad ? {b[3:0], smp_o} : {b[6:0], smp_o[1]};
                    if (smp_oe !== oe_exp) oe_bad++;
                end
                chk($sformatf("rd_%02h_%06h", op, aj), {24'h0, b}, {24'h0, ref_rd(aj)});
            end else begin
                for (int k = 0; k < nb; k++) begin
                    b = wbuf[j] << (quad ? 4 * k : k);
                    sck(quad ? b[7:4] : {3'b000, b[7]});
                    if (smp_oe !== 4'h0) oe_bad++;
                end
                if (known) ref_mem[aj] = wbuf[j];
            end
        end
        for (int k = 0; k < extra; k++) begin
            sck(4'($urandom));
            if (smp_oe !== 4'h0) oe_bad++;
        end
        sio_i = 4'h0;
        #(HALF);
        ce_n = 1'b1;
        #(4 * HALF);
        chk($sformatf("oe_%02h", op), 32'(oe_bad), 32'd0);
        chk($sformatf("oe_idle_%02h", op), {28'h0, sio_oe}, 32'h0);
        exp_w = (known && !rd) ? n : 0;
        chk($sformatf("nwe_%02h", op), 32'(got_w.size()), 32'(exp_w));
        for (int i = 0; i < exp_w && i < got_w.size(); i++)
            chk($sformatf("we_%02h_%0d", op, i), got_w[i], {a + 24'(i), wbuf[i]});
        if (!rd)
            chk($sformatf("re_none_%02h", op), 32'(re_cnt), 32'd0);
    endtask

    initial begin
        logic [7:0]  op;
        logic [23:0] a;
        int          n, extra;

        #20;
        chk("rst_outs", {22'h0, sio_o, sio_oe, mem_re, mem_we}, 32'h0);
        chk("rst_addr", {8'h0, mem_addr}, 32'h0);
        chk("rst_wdata", {24'h0, mem_wdata}, 32'h0);
        rst_n = 1'b1;
        #(2 * HALF);

        env_mem[24'h000100] = 8'hA5; ref_mem[24'h000100] = 8'hA5;
        env_mem[24'h000101] = 8'h3C; ref_mem[24'h000101] = 8'h3C;
        xfer(8'h03, 24'h000100, 2, 0);

        wbuf[0] = 8'hDE; wbuf[1] = 8'hAD;
        xfer(8'h38, 24'h001000, 2, 0);
        xfer(8'hEB, 24'h001000, 2, 0);

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        xfer(8'h02, 24'hFFFFFF, 2, 0);
        xfer(8'h03, 24'hFFFFFF, 2, 0);

        xfer(8'h9F, 24'h123456, 2, 0);
        xfer(8'h03, 24'h000100, 1, 0);

        wbuf[0] = 8'h77;
        xfer(8'h02, 24'h002000, 1, 4);
        xfer(8'h03, 24'h002000, 1, 0);

        // reset in the middle of a quad read data phase
        ce_n = 1'b0;
        #(HALF);
        for (int i = 7; i >= 0; i--) sck({3'b000, 8'hEB >> i});
        for (int i = 5; i >= 0; i--) sck(4'(24'h001000 >> (4 * i)));
        for (int i = 0; i < QD + 2; i++) sck(4'h0);
        #20;
        chk("pre_rst_oe", {28'h0, sio_oe}, 32'hF);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_oe", {28'h0, sio_oe}, 32'h0);
        chk("rst_mid_o", {28'h0, sio_o}, 32'h0);
        chk("rst_mid_strb", {30'h0, mem_re, mem_we}, 32'h0);
        #9;
        ce_n = 1'b1;
        #(2 * HALF);
        rst_n = 1'b1;
        #(2 * HALF);
        xfer(8'h03, 24'h000100, 2, 0);

        for (int t = 0; t < 24; t++) begin
            op = op_tab[$urandom_range(0, 4)];
            a  = ($urandom_range(0, 3) == 0) ? 24'hFFFFFE : {16'h0040, 8'($urandom_range(0, 15))};
            n  = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) wbuf[j] = 8'($urandom);
            extra = (op == 8'h02) ? $urandom_range(0, 7) : (op == 8'h38) ? $urandom_range(0, 1) : 0;
            xfer(op, a, n, extra);
        end

        chk("re_we_overlap", 32'(both_cnt), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_mem_responder.md
# spi_mem_responder

Synthesizable SPI/QSPI memory responder: the device end of the SoC's flash/PSRAM bus (`sclk`, chip-enable, `sio[3:0]`). It oversamples the serial pins on the system clock, decodes a PSRAM-style command subset, and turns each access into byte reads or writes on a simple synchronous memory port. It serves as the FPGA-side PSRAM stand-in on test boards and as the synthesizable bus partner in SoC regression.

## Interface
- `ADDR_BITS`, default 24: address width; the address counter wraps modulo 2^ADDR_BITS.
- `QUAD_DUMMY`, default 6: dummy sclk cycles between address and data for 0xEB.
- `clk` input 1: system clock; must be at least 8× the sclk frequency.
- `rst_n` input 1: reset, asynchronous, active-low.
- `sclk` input 1: serial clock from the initiator, asynchronous to `clk`; SPI mode 0.
- `ce_n` input 1: chip enable, active low, asynchronous.
- `sio_i` input 4: serial data in; bit 0 = MOSI in single-bit mode.
- `sio_o` output 4: serial data out; bit 1 = MISO in single-bit mode.
- `sio_oe` output 4: per-bit output enable, 1 = drive.
- `mem_addr` output ADDR_BITS: byte address for the current read or write.
- `mem_re` output 1: one-cycle read strobe; `mem_rdata` is valid exactly one `clk` later.
- `mem_rdata` input 8: read data.
- `mem_we` output 1: one-cycle write strobe, qualified with `mem_addr` and `mem_wdata`.
- `mem_wdata` output 8: write data.

## Operation
- **Synchronization:** `sclk`, `ce_n` and `sio_i` pass through 2-FF synchronizers. Rise and fall pulses of `sclk` are derived from the synchronized copy. All logic runs on `clk`.
- **Edge usage:** input bits are sampled on the sclk rise pulse. Output bits change on the sclk fall pulse. Data is MSB first.
- **Commands** (the opcode is always 8 serial bits on `sio_i[0]`):
  - 0x03 read: 24 address bits serial, no dummy, data serial on `sio_o[1]`.
  - 0x02 write: 24 address bits serial, data serial.
  - 0xEB quad read: 6 address nibbles on `sio_i[3:0]`, `QUAD_DUMMY` dummy cycles, data nibbles on `sio_o[3:0]`.
  - 0x38 quad write: 6 address nibbles, data nibbles.
- **Address width:** the wire address is always 24 bits. Only its low `ADDR_BITS` bits are used.
- **States:** IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
  - IDLE → CMD on `ce_n` falling (synchronized).
  - CMD → ADDR after 8 bits. An unknown opcode goes to IGNORE instead.
  - ADDR → DUMMY (0xEB with `QUAD_DUMMY`>0), otherwise → RDATA or WDATA.
  - DUMMY → RDATA after `QUAD_DUMMY` rise pulses.
  - RDATA and WDATA persist until `ce_n` rises.
- **Read prefetch:**
  - `mem_re` pulses one `clk` after the address completes. For 0xEB it pulses when the last address nibble is sampled.
  - The captured byte is loaded into the output shifter before the next fall pulse.
  - When a byte's first bit or nibble is driven, the next byte (address+1) is prefetched.
- **Write:** when the 8th bit or 2nd nibble of a byte is sampled, `mem_we` pulses for one `clk` at the current address. The address then increments.
- **Burst wrap:** the address increments per byte and wraps from 2^ADDR_BITS−1 to 0.
- **Output enable:**
  - `sio_oe` = 4'b0010 in RDATA for 0x03.
  - `sio_oe` = 4'b1111 in RDATA for 0xEB, asserted on the first fall pulse after the last dummy rise.
  - `sio_oe` = 0 in every other state.
- **Deselect:**
  - A synchronized `ce_n` rise in any state returns to IDLE within 1 `clk`.
  - `sio_oe` goes to 0 and any partial write byte is discarded (no `mem_we`).
  - Sclk edges while `ce_n` is high are ignored.
- **Reset:** `rst_n` low forces IDLE and clears all counters. It also zeroes `sio_o`, `sio_oe`, `mem_addr`, `mem_re`, `mem_we` and `mem_wdata`. Reset mid-transaction aborts the transaction without a memory strobe.

## Timing
- Pin-to-internal latency is 3 `clk` (2 sync stages plus edge detect).
- A driven bit appears on `sio_o` 3–4 `clk` after the physical sclk falling edge. Hence the 8× ratio: the bit is stable before the next rising edge.
- `mem_re` precedes the first data fall pulse by at least 2 `clk`.
- A `mem_we` pulse is 1 `clk` wide, at most 2 `clk` after the completing rise pulse.
- `mem_re` and `mem_we` are never asserted in the same cycle.

## Test plan
- **Serial read:** mem[0x000100]=0xA5, [0x101]=0x3C. Send 0x03 with address 0x000100, then 16 clocks. Required: MISO returns 0xA5 then 0x3C; `sio_oe`=0010 during data only.
- **Quad write then read:** 0x38 at 0x001000 with nibbles for 0xDE,0xAD. Required: `mem_we` twice with addr 0x1000/0x1001 and data 0xDE/0xAD. Then 0xEB at 0x001000 with 6 dummy cycles. Required: nibbles D,E,A,D; `sio_oe`=1111 only after dummy.
- **Address wrap:** 0x02 write at 0xFFFFFF with 2 bytes 0x11,0x22. Required: writes land at 0xFFFFFF, then 0x000000.
- **Unknown opcode 0x9F:** required: no `mem_re`/`mem_we`, `sio_oe`=0 until `ce_n` high. The next 0x03 transaction works normally.
- **Deselect mid-byte:** 0x02 write sends 12 data bits, then `ce_n` goes high. Required: exactly one `mem_we` (first byte), state IDLE.
- **Async reset during 0xEB data:** assert `rst_n`=0. Required: `sio_oe`, `sio_o` and the strobes go to 0 immediately. After release, a clean 0x03 read returns the correct data.
